div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 46 ++++
 rtl/div_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if -- request/response bundle for div_unit.
//
// Signals
//   start     : request pulse, sampled only while the divider is idle
//   a, b      : dividend / divisor
//   signed_op : 1 = two's-complement divide (only when DIV_SIGNED_EN is defined)
//   hi, lo    : remainder / quotient, registered, held until the next completion
//   busy      : high while the divider is iterating
//   ready     : one-cycle completion strobe
//   div_zero  : one-cycle divide-by-zero flag, coincident with ready
//
// Handshake: a request is accepted on the rising clk edge at which start=1 and
// the divider is idle (busy=0, ready=0); start is ignored at every other edge
// and is never queued. Each accepted request produces exactly one ready pulse
// unless reset intervenes; hi/lo/div_zero are valid in the cycle ready=1.
//
// Configuration macro: DIV_SIGNED_EN adds the signed_op signal.
// -----------------------------------------------------------------------------
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef DIV_SIGNED_EN
    logic             signed_op;
`endif
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             ready;
    logic             div_zero;

`ifdef DIV_SIGNED_EN
    modport master (output start, a, b, signed_op,
                    input  hi, lo, busy, ready, div_zero);
    modport slave  (input  start, a, b, signed_op,
                    output hi, lo, busy, ready, div_zero);
`else
    modport master (output start, a, b,
                    input  hi, lo, busy, ready, div_zero);
    modport slave  (input  start, a, b,
                    output hi, lo, busy, ready, div_zero);
`endif
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle restoring divider, one quotient bit per clock.
//
// Ports
//   clk       : single clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : div_unit_if.slave (start, a, b, [signed_op], hi, lo, busy,
//               ready, div_zero)
//   state_dbg : current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Timing: a request accepted at edge N completes with ready in the cycle after
// edge N+WIDTH; a zero divisor skips iteration and completes after edge N.
//
// Configuration macro: DIV_SIGNED_EN -- when defined, signed_op selects a
// two's-complement divide (magnitude divide plus sign fix-up on the final
// step, no extra cycles). When undefined, every divide is unsigned.
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    div_unit_if.slave  bus,
    output logic [1:0] state_dbg
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;      // partial remainder, one bit wider than operands
    logic [WIDTH-1:0] quo_q;      // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0] div_q;
    logic             neg_q_q;    // negate quotient at completion
    logic             neg_r_q;    // negate remainder at completion
    logic             dz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             sop;
`ifdef DIV_SIGNED_EN
    assign sop = bus.signed_op;
`else
    assign sop = 1'b0;
`endif

    // Operand magnitudes taken at acceptance; the iteration itself is unsigned.
    logic             a_neg, b_neg, b_zero, accept, last_step;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg     = sop & bus.a[WIDTH-1];
    assign b_neg     = sop & bus.b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;
    assign b_zero    = (bus.b == '0);
    assign accept    = (state_q == IDLE) && bus.start;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // One restoring step. The trial difference is computed one bit wider than
    // the partial remainder so its top bit is a clean borrow.
    logic [WIDTH+1:0] shifted, trial;
    logic             borrow;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt, q_res, r_res;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {2'b00, div_q};
    assign borrow  = trial[WIDTH+1];
    assign rem_nxt = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], ~borrow};
    assign q_res   = neg_q_q ? -quo_nxt : quo_nxt;
    assign r_res   = neg_r_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = b_zero ? DONE : CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (accept) begin
            if (b_zero) begin
                // Divide by zero: results are loaded directly, no iteration.
                dz_q <= 1'b1;
                hi_q <= bus.a;
                lo_q <= '1;
            end else begin
                dz_q    <= 1'b0;
                cnt_q   <= '0;
                rem_q   <= '0;
                quo_q   <= a_mag;
                div_q   <= b_mag;
                neg_q_q <= a_neg ^ b_neg;
                neg_r_q <= a_neg;
            end
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (last_step) begin
                hi_q <= r_res;
                lo_q <= q_res;
            end
        end
    end

    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.busy    = (state_q == CALC);
    assign bus.ready   = (state_q == DONE);
    assign bus.div_zero = (state_q == DONE) && dz_q;
    assign state_dbg   = state_q;
endmodule
